affine_ctrl_gen: RTL and testbench

- Loop-nest controller driving the write or read side of a unified buffer.
- Walks a 3-deep iteration domain and emits each point's iteration vector as ctrl_vars[2:0] together with a one-cycle wen/ren strobe.
- Each point is emitted exactly at its scheduled time: OFFSET + S0*c0 + S1*c1 + S2*c2 un-stalled cycles after start.
- One instance per buffer port (e.g. the op_hcompute_*_write side feeding a ub write port).

---
 rtl/affine_ctrl_gen.sv | 118 +++++++++++
 tb/tb_affine_ctrl_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/affine_ctrl_gen.sv
// affine_ctrl_gen: loop-nest controller for one unified-buffer port.
// Walks a 3-deep iteration domain and strobes en_out exactly when the
// cycle counter reaches the affine schedule time of the current point.
module affine_ctrl_gen #(
  parameter int unsigned EXT0   = 1,
  parameter int unsigned EXT1   = 64,
  parameter int unsigned EXT2   = 64,
  parameter int unsigned S0     = 4096,
  parameter int unsigned S1     = 64,
  parameter int unsigned S2     = 1,
  parameter int unsigned OFFSET = 0,
  parameter int unsigned TW     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  output logic             en_out,
  output logic [2:0][15:0] ctrl_vars,
  output logic             done
);

  localparam int unsigned CW = 16;

  // Schedule time of the final point, used to check that it fits in TW bits.
  localparam longint unsigned LAST_T =
      longint'(OFFSET) + longint'(S0) * longint'(EXT0 - 1) +
      longint'(S1) * longint'(EXT1 - 1) + longint'(S2) * longint'(EXT2 - 1);

  // Elaboration-time legality checks: strictly increasing schedule that fits in TW bits.
  if (!((S2 >= 1) &&
        (longint'(S1) >= longint'(S2) * longint'(EXT2)) &&
        (longint'(S0) >= longint'(S1) * longint'(EXT1)))) begin : g_bad_sched
    $error("affine_ctrl_gen: schedule strides not strictly increasing");
  end
  if ((TW < 64) && (LAST_T >= (64'd1 << TW))) begin : g_bad_width
    $error("affine_ctrl_gen: schedule does not fit in TW bits");
  end

  logic [TW-1:0] r_cyc;
  logic [TW-1:0] r_next_time;
  logic [CW-1:0] r_c0;
  logic [CW-1:0] r_c1;
  logic [CW-1:0] r_c2;
  logic          r_done;

  logic          w_restart;
  logic          w_fire;
  logic          w_wrap2;
  logic          w_wrap1;
  logic          w_last;
  logic [CW-1:0] w_c0_n;
  logic [CW-1:0] w_c1_n;
  logic [CW-1:0] w_c2_n;
  logic [TW-1:0] w_next_time_n;

  // Fire decision; a fire coincident with a restart is suppressed.
  always_comb begin
    w_restart = rst | flush;
    w_fire    = ~r_done & ~stall & ~w_restart & (r_cyc == r_next_time);
    w_wrap2   = (r_c2 == CW'(EXT2 - 1));
    w_wrap1   = (r_c1 == CW'(EXT1 - 1));
    w_last    = (r_c0 == CW'(EXT0 - 1)) & w_wrap1 & w_wrap2;
  end

  // Lexicographic advance of the iteration vector and its schedule time.
  always_comb begin
    w_c2_n = w_wrap2 ? '0 : r_c2 + CW'(1);
    w_c1_n = r_c1;
    w_c0_n = r_c0;
    if (w_wrap2) begin
      w_c1_n = w_wrap1 ? '0 : r_c1 + CW'(1);
      if (w_wrap1) begin
        w_c0_n = r_c0 + CW'(1);
      end
    end
    w_next_time_n = TW'(OFFSET) +
                    TW'(S0) * TW'(w_c0_n) +
                    TW'(S1) * TW'(w_c1_n) +
                    TW'(S2) * TW'(w_c2_n);
  end

  // Cycle counter, iteration counters and sticky done.
  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_cyc       <= '0;
      r_next_time <= TW'(OFFSET);
      r_c0        <= '0;
      r_c1        <= '0;
      r_c2        <= '0;
      r_done      <= 1'b0;
    end else begin
      if (~r_done & ~stall) begin
        r_cyc <= r_cyc + TW'(1);
      end
      if (w_fire) begin
        if (w_last) begin
          r_done <= 1'b1;
        end else begin
          r_c0        <= w_c0_n;
          r_c1        <= w_c1_n;
          r_c2        <= w_c2_n;
          r_next_time <= w_next_time_n;
        end
      end
    end
  end

  // Output mapping; index 0 is the outermost loop.
  always_comb begin
    en_out       = w_fire;
    ctrl_vars[0] = r_c0;
    ctrl_vars[1] = r_c1;
    ctrl_vars[2] = r_c2;
    done         = r_done;
  end

endmodule

// File: tb/tb_affine_ctrl_gen.sv
// Directed bench for affine_ctrl_gen across several loop-nest configurations.
module tb_affine_ctrl_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic flush = 1'b0;
  logic stall = 1'b0;

  logic             en_a, en_b, en_c, en_d;
  logic             dn_a, dn_b, dn_c, dn_d;
  logic [2:0][15:0] cv_a, cv_b, cv_c, cv_d;

  affine_ctrl_gen #(.EXT0(1), .EXT1(4), .EXT2(4), .S0(16), .S1(4), .S2(1), .OFFSET(3), .TW(32))
    u_a (.clk(clk), .rst(rst), .flush(flush), .stall(stall), .en_out(en_a), .ctrl_vars(cv_a), .done(dn_a));
  affine_ctrl_gen #(.EXT0(1), .EXT1(3), .EXT2(2), .S0(12), .S1(4), .S2(1), .OFFSET(0), .TW(32))
    u_b (.clk(clk), .rst(rst), .flush(flush), .stall(stall), .en_out(en_b), .ctrl_vars(cv_b), .done(dn_b));
  affine_ctrl_gen #(.EXT0(1), .EXT1(1), .EXT2(1), .S0(4096), .S1(64), .S2(1), .OFFSET(5), .TW(32))
    u_c (.clk(clk), .rst(rst), .flush(flush), .stall(stall), .en_out(en_c), .ctrl_vars(cv_c), .done(dn_c));
  affine_ctrl_gen #(.EXT0(2), .EXT1(2), .EXT2(2), .S0(8), .S1(4), .S2(2), .OFFSET(1), .TW(32))
    u_d (.clk(clk), .rst(rst), .flush(flush), .stall(stall), .en_out(en_d), .ctrl_vars(cv_d), .done(dn_d));

  int total = 0;
  int bad = 0;
  int sel = 0;

  logic             obs_en;
  logic             obs_done;
  logic [2:0][15:0] obs_cv;

  always_comb begin
    obs_en   = en_a;
    obs_done = dn_a;
    obs_cv   = cv_a;
    case (sel)
      1: begin obs_en = en_b; obs_done = dn_b; obs_cv = cv_b; end
      2: begin obs_en = en_c; obs_done = dn_c; obs_cv = cv_c; end
      3: begin obs_en = en_d; obs_done = dn_d; obs_cv = cv_d; end
      default: ;
    endcase
  end

  int          exp_t[$];
  logic [15:0] exp_c0[$];
  logic [15:0] exp_c1[$];
  logic [15:0] exp_c2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s sel=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  function automatic void push(input int t, input int a, input int b, input int c);
    exp_t.push_back(t);
    exp_c0.push_back(16'(a));
    exp_c1.push_back(16'(b));
    exp_c2.push_back(16'(c));
  endfunction

  function automatic void clear();
    exp_t.delete();
    exp_c0.delete();
    exp_c1.delete();
    exp_c2.delete();
  endfunction

  // Reset the nest, check reset outputs, release so the next cycle is cycle 0.
  task automatic start(input int s);
    sel   = s;
    rst   = 1'b1;
    flush = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset en_out", 32'(obs_en), 32'd0);
    chk("reset done", 32'(obs_done), 32'd0);
    chk("reset cv0", 32'(obs_cv[0]), 32'd0);
    chk("reset cv1", 32'(obs_cv[1]), 32'd0);
    chk("reset cv2", 32'(obs_cv[2]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Run n cycles comparing strobes, vectors and done against the expected tables.
  task automatic run(input int n, input int st_lo, input int st_hi, input int fl_cyc, input int done_cyc);
    int   idx;
    int   nstr;
    logic exp_en;
    idx  = 0;
    nstr = 0;
    for (int k = 0; k < n; k++) begin
      stall = (k >= st_lo) && (k <= st_hi);
      flush = (k == fl_cyc);
      @(negedge clk);
      exp_en = (idx < exp_t.size()) && (exp_t[idx] == k);
      chk($sformatf("en_out cyc%0d", k), 32'(obs_en), 32'(exp_en));
      if (obs_en === 1'b1) nstr++;
      if (exp_en) begin
        chk($sformatf("cv0 cyc%0d", k), 32'(obs_cv[0]), 32'(exp_c0[idx]));
        chk($sformatf("cv1 cyc%0d", k), 32'(obs_cv[1]), 32'(exp_c1[idx]));
        chk($sformatf("cv2 cyc%0d", k), 32'(obs_cv[2]), 32'(exp_c2[idx]));
        idx++;
      end
      chk($sformatf("done cyc%0d", k), 32'(obs_done), 32'(k >= done_cyc));
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    flush = 1'b0;
    chk("strobe count", 32'(nstr), 32'(exp_t.size()));
  endtask

  initial begin
    // Dense 1x4x4 nest, offset 3: strobes 3..18, done from 19.
    clear();
    for (int i = 0; i < 16; i++) push(3 + i, 0, i / 4, i % 4);
    start(0);
    run(24, 1000, -1, -1, 19);

    // Gapped 1x3x2 nest with idle cycles between rows.
    clear();
    push(0, 0, 0, 0);
    push(1, 0, 0, 1);
    push(4, 0, 1, 0);
    push(5, 0, 1, 1);
    push(8, 0, 2, 0);
    push(9, 0, 2, 1);
    start(1);
    run(14, 1000, -1, -1, 10);

    // Stall in cycles 5..7 slips the schedule by three cycles.
    clear();
    push(3, 0, 0, 0);
    push(4, 0, 0, 1);
    for (int i = 2; i < 16; i++) push(6 + i, 0, i / 4, i % 4);
    start(0);
    run(26, 5, 7, -1, 22);

    // Flush in cycle 10 suppresses that strobe and restarts at cycle 14.
    clear();
    for (int i = 0; i < 7; i++) push(3 + i, 0, i / 4, i % 4);
    for (int i = 0; i < 16; i++) push(14 + i, 0, i / 4, i % 4);
    start(0);
    run(34, 1000, -1, 10, 30);

    // Single-point nest, run twice across a reset for an identical trace.
    clear();
    push(5, 0, 0, 0);
    start(2);
    run(9, 1000, -1, -1, 6);
    start(2);
    run(9, 1000, -1, -1, 6);

    // 2x2x2 nest with stride 2 innermost; outer counter rolls at cycle 9.
    clear();
    for (int i = 0; i < 8; i++) push(1 + 2 * i, i / 4, (i / 2) % 2, i % 2);
    start(3);
    run(20, 1000, -1, -1, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
